pipe_ripple_adder: RTL
======================

Name: pipe_ripple_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add into NSEG = WIDTH/SEG_W segments. Each segment is a ripple adder in its own pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides, full back-pressure, one result per cycle at steady state.
- Datapath arithmetic primitive for wide counters and accumulators in the design.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG_W.
- SEG_W, 4, bits per pipeline segment. Latency is NSEG = WIDTH/SEG_W cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operands present.
- in_ready, output, 1, block accepts operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- c_in, input, 1, carry into bit 0.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, result bits.
- c_out, output, 1, carry out of bit WIDTH-1.

Behaviour:
- Reset (async, rst=1): all stage valid bits, carries and data registers clear to 0. Outputs are out_valid=0, sum=0, c_out=0. in_ready=1 during and after reset.
  - Reset mid-operation discards all in-flight transactions; no partial result is ever presented.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational).
  - When en=0 every stage holds, including valid bits.
  - When en=1 every stage advances by one.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid while en=0 is ignored; the source must hold its data.
- Stage k (0..NSEG-1) computes segment k: {carry_k+1, sum_seg_k} = a_seg_k + b_seg_k + carry_k, with carry_0 = c_in.
- Skew registers:
  - Unprocessed upper operand segments travel forward with the transaction.
  - Completed lower sum segments travel forward with it.
  - A transaction launched at input cycle T is visible on sum/c_out with out_valid=1 at cycle T+NSEG (posedge count) when no stall occurs.
- Bubbles: a stage whose valid is 0 still shifts. Downstream valid bits carry the 0, so gaps propagate without merging.
- Ordering: strictly in order; no reordering or dropping.
- Arithmetic is unsigned modulo 2^WIDTH, with c_out = bit WIDTH of the exact sum.
  - Wrap-around example: all-ones + 1 gives sum=0, c_out=1.
- Output stability: while out_valid=1 and out_ready=0, sum and c_out hold unchanged.
- Degenerate case: NSEG=1 (SEG_W=WIDTH) gives a single registered adder with latency 1.
- Simultaneous events: an input accept and an output accept in the same cycle are legal and sustain full throughput.

Optional Feature:
- Macro ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit, sampled with a/b).
  - When sub=1, b is bitwise inverted and c_in is overridden to 1, giving a - b; c_out=1 means no borrow.
  - Adds output port ovf (1 bit): signed two's-complement overflow of the selected operation, aligned with sum, reset 0.
- When undefined: no sub/ovf ports and addition only; behaviour is otherwise identical.

Decomposition:
- Shared package adder_pkg:
  - function nseg(width, seg_w), returning the segment count.
  - A localparam check macro/assertion requiring WIDTH % SEG_W == 0.
- One sub-module, rca_seg:
  - Combinational SEG_W-bit ripple-carry adder with c_in and c_out, built from full-adder bit cells.
  - Instantiated once per stage via generate.

Test Plan (WIDTH=16, SEG_W=4, latency 4):
- Reset then single op: a=16'h0001, b=16'h0000, c_in=0 -> out_valid high 4 cycles later, sum=16'h0001, c_out=0.
- Full carry ripple across all segments: a=16'hFFFF, b=16'h0001 -> sum=16'h0000, c_out=1.
- Back-to-back streaming:
  - Stimulus: 10 consecutive ops, out_ready=1, including a=16'h00A0, b=16'h0030 -> sum=16'h00D0 and a=16'hD000, b=16'hA000 -> sum=16'h7000, c_out=1.
  - Response: one result per cycle, in order, no gaps.
- Back-pressure: out_ready=0 for 6 cycles with the pipeline full -> in_ready=0, sum/c_out/out_valid stable. On release, results resume in order with none lost or duplicated.
- Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0 and sum=0 immediately (async); no stale result appears after reset release.
- With ADDER_SUB_EN: a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, c_out=1, ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - segment sizing helpers shared by the pipelined ripple adder
package adder_pkg;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit seg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// rtl/rca_seg.sv - combinational SEG_W-bit ripple-carry segment built from full-adder cells
module rca_seg
    import adder_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             c_i,
    output logic [SEG_W-1:0] s_o,
    output logic             c_o
);

    logic [SEG_W:0] cy;

    assign cy[0] = c_i;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        assign s_o[i]    = a_i[i] ^ b_i[i] ^ cy[i];
        assign cy[i + 1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = cy[SEG_W];

endmodule

// File: rtl/pipe_ripple_adder.sv
// rtl/pipe_ripple_adder.sv - WIDTH-bit adder split into SEG_W-bit pipelined ripple stages
// Optional subtract mode and signed-overflow flag under ADDER_SUB_EN.
module pipe_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_SUB_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    if (!seg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
        $error("pipe_ripple_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

`ifdef ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | c_in;
`else
    assign b_eff = b;
    assign c_eff = c_in;
`endif

    // Whole pipe moves as one: any output stall freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage k keeps finished low sum segments plus the still-unadded upper operand segments.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG_W;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]         a_in;
        logic [RW-1:0]         b_in;
        logic                  cy_in;
        logic                  v_in;
        logic [SEG_W-1:0]      seg_s;
        logic                  seg_c;
        logic [LO+SEG_W-1:0]   s_d;
        logic [LO+SEG_W-1:0]   s_q;
        logic                  v_q;
        logic                  c_q;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign cy_in = c_eff;
            assign v_in  = in_valid;
            assign s_d   = seg_s;
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign cy_in = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign s_d   = {seg_s, g_stage[k-1].s_q};
        end

        rca_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a_i (a_in[SEG_W-1:0]),
            .b_i (b_in[SEG_W-1:0]),
            .c_i (cy_in),
            .s_o (seg_s),
            .c_o (seg_c)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= seg_c;
                s_q <= s_d;
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [RW-SEG_W-1:0] a_q;
            logic [RW-SEG_W-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[RW-1:SEG_W];
                    b_q <= b_in[RW-1:SEG_W];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].v_q;
    assign sum       = g_stage[NSEG-1].s_q;
    assign c_out     = g_stage[NSEG-1].c_q;

`ifdef ADDER_SUB_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow when both operand signs agree and the result sign differs.
    assign ovf_d = (g_stage[NSEG-1].a_in[SEG_W-1] == g_stage[NSEG-1].b_in[SEG_W-1]) &&
                   (g_stage[NSEG-1].seg_s[SEG_W-1] != g_stage[NSEG-1].a_in[SEG_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
